// File: rtl/vga_pkg.sv
// Shared 640x480@60 VGA timing constants, used by the timing generator and by the
// character generator / box renderer downstream.
package vga_pkg;

  localparam int CLK_DIV      = 4;
  localparam int H_DISPLAY    = 640;
  localparam int H_FRONT      = 16;
  localparam int H_RETRACE    = 96;
  localparam int H_BACK       = 48;
  localparam int V_DISPLAY    = 480;
  localparam int V_FRONT      = 10;
  localparam int V_RETRACE    = 2;
  localparam int V_BACK       = 33;
  localparam int BLINK_FRAMES = 30;

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_RETRACE + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_RETRACE + V_BACK;

  localparam int COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  function automatic logic in_range(input coord_t v, input coord_t lo, input coord_t hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_pixel_div.sv
// Mod-CLK_DIV counter producing a one-clk pixel enable on the last count of each period.
module vga_pixel_div #(
  parameter int CLK_DIV = vga_pkg::CLK_DIV
) (
  input  logic clk,
  input  logic reset_n,
  output logic p_tick
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  generate
    if (CLK_DIV < 2) begin : g_div_chk
      $error("CLK_DIV must be at least 2 so p_tick stays low in reset");
    end
  endgenerate

  logic [DIV_W-1:0] r_div_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div_cnt <= '0;
    end else if (r_div_cnt == DIV_LAST) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  assign p_tick = (r_div_cnt == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel enable, x/y counters, active-low syncs, video_on, frame strobe, cursor blink.
// Define VGA_ALIGN_DELAY_EN to delay hsync/vsync/video_on by 2 clks (font ROM read + RGB register).
module vga_timing_gen #(
  parameter int CLK_DIV      = vga_pkg::CLK_DIV,
  parameter int H_DISPLAY    = vga_pkg::H_DISPLAY,
  parameter int H_FRONT      = vga_pkg::H_FRONT,
  parameter int H_RETRACE    = vga_pkg::H_RETRACE,
  parameter int H_BACK       = vga_pkg::H_BACK,
  parameter int V_DISPLAY    = vga_pkg::V_DISPLAY,
  parameter int V_FRONT      = vga_pkg::V_FRONT,
  parameter int V_RETRACE    = vga_pkg::V_RETRACE,
  parameter int V_BACK       = vga_pkg::V_BACK,
  parameter int BLINK_FRAMES = vga_pkg::BLINK_FRAMES
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic       p_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       frame_tick,
  output logic       parpadeo
);

  import vga_pkg::*;

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_RETRACE + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_RETRACE + V_BACK;

  localparam coord_t X_LAST   = COORD_W'(H_TOTAL - 1);
  localparam coord_t Y_LAST   = COORD_W'(V_TOTAL - 1);
  localparam coord_t X_VIS    = COORD_W'(H_DISPLAY);
  localparam coord_t Y_VIS    = COORD_W'(V_DISPLAY);
  localparam coord_t HS_START = COORD_W'(H_DISPLAY + H_FRONT);
  localparam coord_t HS_END   = COORD_W'(H_DISPLAY + H_FRONT + H_RETRACE - 1);
  localparam coord_t VS_START = COORD_W'(V_DISPLAY + V_FRONT);
  localparam coord_t VS_END   = COORD_W'(V_DISPLAY + V_FRONT + V_RETRACE - 1);

  localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

  generate
    if (H_TOTAL > 1024) begin : g_h_chk
      $error("H_TOTAL does not fit the 10-bit pixel_x counter");
    end
    if (V_TOTAL > 1024) begin : g_v_chk
      $error("V_TOTAL does not fit the 10-bit pixel_y counter");
    end
  endgenerate

  logic                w_p_tick;
  logic                w_x_last;
  logic                w_y_last;
  coord_t              w_x_next;
  coord_t              w_y_next;
  logic                w_video_on;
  logic                w_frame_tick;
  coord_t              r_x;
  coord_t              r_y;
  logic                r_hsync;
  logic                r_vsync;
  logic [BLINK_W-1:0]  r_blink_cnt;
  logic                r_parpadeo;

  vga_pixel_div #(
    .CLK_DIV (CLK_DIV)
  ) u_pixel_div (
    .clk     (clk),
    .reset_n (reset_n),
    .p_tick  (w_p_tick)
  );

  assign w_x_last = (r_x == X_LAST);
  assign w_y_last = (r_y == Y_LAST);

  always_comb begin
    w_x_next = r_x + 1'b1;
    w_y_next = r_y;
    if (w_x_last) begin
      w_x_next = '0;
      w_y_next = w_y_last ? '0 : r_y + 1'b1;
    end
  end

  // Syncs decode the next counter values so they flip on the same edge as pixel_x/pixel_y.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x     <= '0;
      r_y     <= '0;
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
    end else if (w_p_tick) begin
      r_x     <= w_x_next;
      r_y     <= w_y_next;
      r_hsync <= !in_range(w_x_next, HS_START, HS_END);
      r_vsync <= !in_range(w_y_next, VS_START, VS_END);
    end
  end

  assign w_video_on   = (r_x < X_VIS) && (r_y < Y_VIS);
  assign w_frame_tick = w_p_tick && w_x_last && w_y_last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_blink_cnt <= '0;
      r_parpadeo  <= 1'b0;
    end else if (w_frame_tick) begin
      if (r_blink_cnt == BLINK_LAST) begin
        r_blink_cnt <= '0;
        r_parpadeo  <= ~r_parpadeo;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

`ifdef VGA_ALIGN_DELAY_EN
  logic [1:0] r_hs_pipe;
  logic [1:0] r_vs_pipe;
  logic [1:0] r_von_pipe;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hs_pipe  <= 2'b11;
      r_vs_pipe  <= 2'b11;
      r_von_pipe <= 2'b00;
    end else begin
      r_hs_pipe  <= {r_hs_pipe[0], r_hsync};
      r_vs_pipe  <= {r_vs_pipe[0], r_vsync};
      r_von_pipe <= {r_von_pipe[0], w_video_on};
    end
  end

  assign hsync    = r_hs_pipe[1];
  assign vsync    = r_vs_pipe[1];
  assign video_on = r_von_pipe[1];
`else
  assign hsync    = r_hsync;
  assign vsync    = r_vsync;
  assign video_on = w_video_on;
`endif

  assign p_tick     = w_p_tick;
  assign pixel_x    = r_x;
  assign pixel_y    = r_y;
  assign frame_tick = w_frame_tick;
  assign parpadeo   = r_parpadeo;

endmodule
